axi_lite_reg_checker: RTL and testbench

Synthesizable, parametrised AXI4-Lite master that runs a write/read-back/compare sweep over NUM_REGS consecutive slave registers. It replaces the simulation-only 4-register BFM write/read test with a block that can sit inside a block design in front of any AXI4-Lite slave IP. It adds selectable ordering modes, a seeded data pattern, response checking, per-transaction timeout and an error summary.

---
 rtl/axi_lite_reg_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_reg_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_checker.sv
// AXI4-Lite master that writes a seeded pattern to NUM_REGS consecutive slave registers,
// reads each one back and reports mismatches, error responses and handshake timeouts.
module axi_lite_reg_checker #(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          NUM_REGS           = 4,
    parameter int          ADDR_STRIDE        = 4,
    parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES     = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              start,
    input  logic                              mode,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [7:0]                        err_count,
    output logic [7:0]                        first_err_idx,
    output logic                              timeout_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_WR    | AW and W presented for current index
    // S_WRESP | waiting for write response
    // S_RD    | AR presented for current index
    // S_RDATA | waiting for read data
    // S_CHECK | compare captured read data against expected pattern
    // S_FIN   | one-cycle done pulse, result published
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_CHECK, S_FIN
    } state_t;

    localparam int              AW       = C_M_AXI_ADDR_WIDTH;
    localparam int              DW       = C_M_AXI_DATA_WIDTH;
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      LAST_IDX = 8'(NUM_REGS - 1);
    localparam logic [AW-1:0]   BASE_A   = AW'(BASE_ADDR);
    localparam logic [AW-1:0]   STRIDE_A = AW'(ADDR_STRIDE);

    state_t          state, state_nxt;
    logic [7:0]      idx;
    logic            mode_q;
    logic [DW-1:0]   seed_q;
    logic            aw_done, w_done;
    logic [TW-1:0]   tmr;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      rresp_q;
    logic            pass_q;

    logic            err_hit, tmo_hit, idx_inc, idx_clr;
    logic            last, tmr_zero;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   exp_data;

    function automatic logic resp_bad(input logic [1:0] r);
        return (r == 2'b10) || (r == 2'b11);
    endfunction

    assign last     = (idx == LAST_IDX);
    assign tmr_zero = (tmr == '0);
    assign cur_addr = BASE_A + AW'(idx) * STRIDE_A;
    assign exp_data = seed_q + DW'(idx);

    always_comb begin
        state_nxt = state;
        err_hit   = 1'b0;
        tmo_hit   = 1'b0;
        idx_inc   = 1'b0;
        idx_clr   = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_WR;
            S_WR: begin
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
                    state_nxt = S_WRESP;
                else if (tmr_zero)
                    tmo_hit = 1'b1;
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    err_hit = resp_bad(M_AXI_BRESP);
                    if (mode_q && !last) begin
                        state_nxt = S_WR;
                        idx_inc   = 1'b1;
                    end else begin
                        state_nxt = S_RD;
                        idx_clr   = mode_q;
                    end
                end else if (tmr_zero) begin
                    tmo_hit = 1'b1;
                end
            end
            S_RD: begin
                if (M_AXI_ARREADY)  state_nxt = S_RDATA;
                else if (tmr_zero)  tmo_hit = 1'b1;
            end
            S_RDATA: begin
                if (M_AXI_RVALID)   state_nxt = S_CHECK;
                else if (tmr_zero)  tmo_hit = 1'b1;
            end
            S_CHECK: begin
                err_hit = resp_bad(rresp_q) || (rdata_q != exp_data);
                if (last) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = mode_q ? S_RD : S_WR;
                    idx_inc   = 1'b1;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A timeout abandons the handshake: VALIDs drop without READY. This is the
        // one deliberate AXI rule break, taken so a dead slave cannot hang the sweep.
        if (tmo_hit) begin
            state_nxt = S_FIN;
            err_hit   = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= S_IDLE;
            idx           <= '0;
            mode_q        <= 1'b0;
            seed_q        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            tmr           <= TMR_LOAD;
            rdata_q       <= '0;
            rresp_q       <= 2'b00;
            pass_q        <= 1'b0;
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
            timeout_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state)
                tmr <= TMR_LOAD;
            else if (!tmr_zero)
                tmr <= tmr - 1'b1;

            if (state == S_IDLE && start) begin
                idx           <= '0;
                mode_q        <= mode;
                seed_q        <= seed;
                pass_q        <= 1'b0;
                err_count     <= 8'd0;
                first_err_idx <= 8'hFF;
                timeout_err   <= 1'b0;
            end

            if (idx_clr)
                idx <= '0;
            else if (idx_inc)
                idx <= idx + 8'd1;

            if (state != S_WR) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (M_AXI_AWREADY) aw_done <= 1'b1;
                if (M_AXI_WREADY)  w_done  <= 1'b1;
            end

            if (state == S_RDATA && M_AXI_RVALID) begin
                rdata_q <= M_AXI_RDATA;
                rresp_q <= M_AXI_RRESP;
            end

            if (err_hit) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                if (err_count == 8'd0)  first_err_idx <= idx;
            end
            if (tmo_hit) timeout_err <= 1'b1;

            if (state == S_FIN) pass_q <= (err_count == 8'd0);
        end
    end

    assign busy = (state != S_IDLE) && (state != S_FIN);
    assign done = (state == S_FIN);
    assign pass = done ? (err_count == 8'd0) : pass_q;

    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state == S_WR) && !aw_done;
    assign M_AXI_WDATA   = exp_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state == S_WR) && !w_done;
    assign M_AXI_BREADY  = (state == S_WRESP);
    assign M_AXI_ARADDR  = cur_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state == S_RD);
    assign M_AXI_RREADY  = (state == S_RDATA);

endmodule

// File: tb/tb_axi_lite_reg_checker.sv
// Directed bench for axi_lite_reg_checker: RAM slave model with injectable ready skew,
// stuck register, error responses and a dead read-address channel.
module tb_axi_lite_reg_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] seed = '0;
    logic        busy, done, pass, timeout_err;
    logic [7:0]  err_count, first_err_idx;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int failures = 0;

    // slave behaviour knobs
    int   stuck_idx = -1;
    int   bresp_err_idx = -1;
    int   rresp_err_idx = -1;
    logic ar_block = 1'b0;
    logic skew = 1'b0;

    always #5 clk = ~clk;

    axi_lite_reg_checker #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(4),
        .ADDR_STRIDE(4), .BASE_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .timeout_err(timeout_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [16];
    int          aw_wait, w_wait, wr_n;
    logic        have_aw, have_w;
    logic [31:0] aw_addr_q, w_data_q;

    // per-write AW/W ready delays; alternates which channel is accepted first
    function automatic int dly_aw(input int n);
        case (n % 4) 0: return 3; 1: return 0; 2: return 2; default: return 5; endcase
    endfunction
    function automatic int dly_w(input int n);
        case (n % 4) 0: return 0; 1: return 4; 2: return 2; default: return 1; endcase
    endfunction

    assign awready = awvalid && (aw_wait >= (skew ? dly_aw(wr_n) : 0));
    assign wready  = wvalid  && (w_wait  >= (skew ? dly_w(wr_n)  : 0));
    assign arready = arvalid && !ar_block;

    always @(posedge clk) begin : slave
        logic        got_aw, got_w;
        logic [31:0] a, d;
        logic [3:0]  ri;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            aw_wait <= 0; w_wait <= 0; wr_n <= 0;
            have_aw <= 1'b0; have_w <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            got_aw = have_aw || (awvalid && awready);
            got_w  = have_w  || (wvalid && wready);
            a = have_aw ? aw_addr_q : awaddr;
            d = have_w  ? w_data_q  : wdata;
            if (bvalid && bready) bvalid <= 1'b0;
            if (got_aw && got_w) begin
                if (int'(a[5:2]) != stuck_idx) mem[a[5:2]] <= d;
                bvalid  <= 1'b1;
                bresp   <= (int'(a[5:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
                have_aw <= 1'b0;
                have_w  <= 1'b0;
                wr_n    <= wr_n + 1;
            end else begin
                if (awvalid && awready) begin have_aw <= 1'b1; aw_addr_q <= awaddr; end
                if (wvalid && wready)   begin have_w  <= 1'b1; w_data_q  <= wdata;  end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                ri = araddr[5:2];
                rvalid <= 1'b1;
                rdata  <= (int'(ri) == stuck_idx) ? 32'h0 : mem[ri];
                rresp  <= (int'(ri) == rresp_err_idx) ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic m, input logic [31:0] s);
        @(posedge clk); #1;
        mode = m; seed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one sweep; cyc counts cycles from the first busy cycle to the done cycle.
    task automatic run_sweep(input logic m, input logic [31:0] s, input int inj,
                             input logic hold_chk, output int cyc,
                             output int aw_at_ar, output int ar_hi);
        logic        pend_aw, pend_w, pend_ar;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        int          aw_n;
        pend_aw = 0; pend_w = 0; pend_ar = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        aw_n = 0; aw_at_ar = -1; ar_hi = 0; cyc = 0;
        pulse_start(m, s);
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_val("busy_rise", busy, 1);
            if (hold_chk) begin
                if (pend_aw) check_val("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
                if (pend_w)  check_val("w_hold",  {wvalid, wdata},   {1'b1, p_wdata});
                if (pend_ar) check_val("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            end
            pend_aw = awvalid && !awready; p_awaddr = awaddr;
            pend_w  = wvalid && !wready;   p_wdata  = wdata;
            pend_ar = arvalid && !arready; p_araddr = araddr;
            if (awvalid && awready) aw_n++;
            if (arvalid && arready && aw_at_ar < 0) aw_at_ar = aw_n;
            if (arvalid) ar_hi++;
            start = (inj != 0) && (cyc == inj);
            if (start) begin seed = ~s; mode = ~m; end
            if (done) break;
        end
        start = 1'b0;
        check_val("done_seen", done, 1);
        check_val("busy_at_done", busy, 0);
        @(negedge clk);
        check_val("done_one_cycle", done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, aw_at_ar, ar_hi, dn;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_flags", {busy, done, pass, timeout_err}, 4'b0000);
        check_val("rst_err_count", err_count, 8'h00);
        check_val("rst_first_err", first_err_idx, 8'hFF);
        check_val("rst_channels", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        rst_n = 1'b1;

        // zero-wait, mode 0
        run_sweep(1'b0, 32'h0101FFFF, 0, 1'b1, cyc, aw_at_ar, ar_hi);
        check_val("m0_latency", cyc, 21);
        check_val("m0_pass", pass, 1);
        check_val("m0_err", err_count, 0);
        check_val("m0_first", first_err_idx, 8'hFF);
        check_val("m0_tmo", timeout_err, 0);
        check_val("m0_mem0", mem[0], 32'h0101FFFF);
        check_val("m0_mem1", mem[1], 32'h01020000);
        check_val("m0_mem2", mem[2], 32'h01020001);
        check_val("m0_mem3", mem[3], 32'h01020002);
        check_val("strb_prot", {wstrb, awprot, arprot}, {4'hF, 6'b0});

        // zero-wait, mode 1: every write precedes the first read
        run_sweep(1'b1, 32'hDEAD0011, 0, 1'b1, cyc, aw_at_ar, ar_hi);
        check_val("m1_aw_before_ar", aw_at_ar, 4);
        check_val("m1_latency", cyc, 21);
        check_val("m1_pass", pass, 1);
        check_val("m1_mem3", mem[3], 32'hDEAD0014);

        // AW/W ready skew in both orders
        skew = 1'b1;
        run_sweep(1'b0, 32'h5A5A0000, 0, 1'b1, cyc, aw_at_ar, ar_hi);
        skew = 1'b0;
        check_val("skew_pass", pass, 1);
        check_val("skew_err", err_count, 0);
        check_val("skew_mem1", mem[1], 32'h5A5A0001);

        // register 2 stuck at zero; a start pulse mid-sweep must be ignored
        stuck_idx = 2;
        run_sweep(1'b0, 32'hABCD0001, 5, 1'b1, cyc, aw_at_ar, ar_hi);
        stuck_idx = -1;
        check_val("stuck_latency", cyc, 21);
        check_val("stuck_err", err_count, 1);
        check_val("stuck_first", first_err_idx, 2);
        check_val("stuck_pass", pass, 0);

        // SLVERR on write response of 1 and read response of 3
        bresp_err_idx = 1; rresp_err_idx = 3;
        run_sweep(1'b0, 32'h12345678, 0, 1'b1, cyc, aw_at_ar, ar_hi);
        bresp_err_idx = -1; rresp_err_idx = -1;
        check_val("resp_err", err_count, 2);
        check_val("resp_first", first_err_idx, 1);
        check_val("resp_pass", pass, 0);
        check_val("resp_tmo", timeout_err, 0);

        // dead AR channel: abort after 16 cycles of ARVALID
        ar_block = 1'b1;
        run_sweep(1'b0, 32'h00000000, 0, 1'b0, cyc, aw_at_ar, ar_hi);
        ar_block = 1'b0;
        check_val("tmo_arvalid_cycles", ar_hi, 16);
        check_val("tmo_latency", cyc, 19);
        check_val("tmo_flag", timeout_err, 1);
        check_val("tmo_err", err_count, 1);
        check_val("tmo_first", first_err_idx, 0);
        check_val("tmo_pass", pass, 0);
        check_val("tmo_arvalid_low", arvalid, 0);

        // reset mid-sweep, after an error has been counted
        rresp_err_idx = 0;
        pulse_start(1'b0, 32'h00000000);
        repeat (6) @(negedge clk);
        check_val("pre_rst_err", err_count, 1);
        check_val("pre_rst_awvalid", awvalid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_flags", {busy, done, pass, timeout_err}, 4'b0000);
        check_val("midrst_err", err_count, 0);
        check_val("midrst_first", first_err_idx, 8'hFF);
        check_val("midrst_channels", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        rst_n = 1'b1;
        rresp_err_idx = -1;
        dn = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check_val("no_done_after_rst", dn, 0);

        run_sweep(1'b0, 32'h0101FFFF, 0, 1'b1, cyc, aw_at_ar, ar_hi);
        check_val("recover_latency", cyc, 21);
        check_val("recover_pass", pass, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
